ysyx_22040931_ex_muldiv: RTL
============================

# ysyx_22040931_ex_muldiv

Multi-cycle RV64M multiply/divide unit for the EX stage, parametrised in datapath width. It sits beside the single-cycle ALU. EX routes M-extension ops here through a valid/ready handshake, then stalls the pipeline on `in_ready`/`out_valid`. It adds what the single-cycle EX cannot do: iterative radix-2 multiply and divide, 32-bit word-mode ops, RISC-V divide corner cases, and pipeline flush.

## Interface
Parameters:
- `XLEN`, 64, datapath width; must be 32 or 64. Word-mode ops are legal only when `XLEN`=64.
- `TAG_W`, 5, width of the destination-register tag carried with each op.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  aborts any op in flight; sampled on the clock edge.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request; high only in IDLE.
- `op`  in  4  `op[3]` selects word mode. `op[2:0]` = funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src1`, `src2`  in  XLEN  rs1 and rs2 operands.
- `rd_i`  in  TAG_W  destination tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  XLEN  result.
- `rd_o`  out  TAG_W  tag of the result.
- `busy`  out  1  high in MUL, DIV or DONE.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset values: state=IDLE, `out_valid`=0, `out_data`=0, `rd_o`=0, counter=0, `busy`=0. `in_ready`=1 once reset is released.
- Accept: `in_valid`&&`in_ready` at an edge latches `op` and `rd_i`, prepares the operands and loads the counter.
  - W = 32 in word mode, otherwise XLEN.
  - Operands are the raw values, or sign-extended or zero-extended from bit 31 in word mode, as required by the signedness of `op`.
- Next state after accept:
  - funct3 < 4: MUL.
  - Divide with divisor (the low W bits) = 0: DONE directly.
  - Signed divide with dividend = most-negative W-bit value and divisor = -1: DONE directly.
  - Any other divide: DIV.
- MUL: shift-add on magnitudes, producing a 2W-bit product, one bit per cycle. The sign is fixed up at the end.
  - MUL takes the low W bits.
  - MULH, MULHSU and MULHU take the high W bits.
  - MULH is signed × signed, MULHSU is signed × unsigned, MULHU is unsigned × unsigned.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
  - Signed quotient sign = sign(a) XOR sign(b).
  - Signed remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones (W bits), remainder = dividend.
- Signed overflow: quotient = dividend, remainder = 0.
- Word mode: the W=32 result is sign-extended from bit 31 to XLEN. This applies to MULW, DIVW, DIVUW, REMW and REMUW.
- Counter: decrements by one each cycle in MUL or DIV. The edge where it goes 1→0 writes `out_data`, sets `out_valid` and enters DONE.
- DONE: holds `out_data`/`rd_o` stable with `out_valid`=1 until `out_ready`. On the handshake edge the unit returns to IDLE and `out_valid`=0.
- `flush` at an edge forces IDLE with `out_valid`=0, from any state.
  - `flush` wins over a simultaneous accept; that request is dropped.
  - `flush` wins over a simultaneous output handshake; that result is discarded.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for `clk`.

## Timing
- Accept at edge E0. The W iteration edges are E1..EW. `out_valid` rises after EW.
- MUL/DIV latency: W+1 cycles from request to first-valid cycle. That is 65 cycles for XLEN=64 and 33 cycles in word mode.
- Corner-case divides: `out_valid` rises after E1, 1 cycle after the request.
- `in_ready` is low from E0 until the edge after the output handshake. There is no accept in the same cycle as the result handshake, so the minimum issue interval is latency+1.
- `in_ready` and `out_valid` are registered state decodes, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- XLEN=64, MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF → `out_data`=0xFFFF_FFFF_FFFF_FFFE; `out_valid` rises 65 cycles after accept; `rd_o` equals the accepted tag.
- DIV, src1=-7, src2=2 → quotient -3. REM with the same operands → remainder -1. DIVU with src2=0 → 0xFFFF_FFFF_FFFF_FFFF, valid 1 cycle after accept.
- DIV with src1=0x8000_0000_0000_0000 and src2=-1 → quotient 0x8000_0000_0000_0000. REM with the same operands → remainder 0. Both valid 1 cycle after accept.
- Word mode: MULW, src1=0x0000_0000_7FFF_FFFF, src2=2 → 0xFFFF_FFFF_FFFF_FFFE, valid after 33 cycles. DIVUW, src1=0xFFFF_FFFF_8000_0000, src2=1 → 0xFFFF_FFFF_8000_0000.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_data` stays stable and `in_ready` stays 0. Then `out_ready`=1 → the unit is in IDLE next cycle with `in_ready`=1.
- Flush: assert `flush` during cycle 20 of a DIV → IDLE next cycle with no `out_valid` pulse. Also assert `flush` together with `in_valid` in IDLE → request dropped. Separately, drop `rst_n` mid-MUL → outputs go to 0 immediately.

Source files
------------

// File: rtl/ysyx_22040931_ex_muldiv.sv
// rtl/ysyx_22040931_ex_muldiv.sv - iterative RV64M multiply/divide unit for the EX stage
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   flush                aborts any operation in flight
//   in_valid/in_ready    request handshake; op, src1, src2 and rd_i are taken on accept
//   out_valid/out_ready  result handshake; out_data and rd_o are held until it completes
//   busy                 an operation is running or its result is waiting

module ysyx_22040931_ex_muldiv #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] rd_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] rd_o,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [2:0]        f3_q;
    logic              word_q;
    logic              a_neg_q;
    logic              b_neg_q;
    logic [CW-1:0]     cnt;
    // x: shifting operand (multiplier for MUL, dividend -> quotient for DIV)
    // y: fixed operand (multiplicand for MUL, divisor for DIV)
    logic [XLEN-1:0]   x_q;
    logic [XLEN-1:0]   y_q;
    logic [2*XLEN-1:0] p_q;
    logic [XLEN:0]     r_q;

    // Sign- or zero-extend the low 32 bits of v to XLEN.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] t;
        t = v << (XLEN - 32);
        if (sgn)
            ext32 = XLEN'($signed(t) >>> (XLEN - 32));
        else
            ext32 = t >> (XLEN - 32);
    endfunction

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Accept-side operand preparation
    logic            word;
    logic            is_div;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] min_w;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] corner_res;
    logic [XLEN-1:0] corner_raw;

    always_comb begin
        word   = (XLEN == 64) && op[3];
        is_div = op[2];
        a_sgn  = is_div ? ~op[0] : (op[1:0] != 2'd3);
        b_sgn  = is_div ? ~op[0] : ~op[1];
        a_ext  = word ? ext32(src1, a_sgn) : src1;
        b_ext  = word ? ext32(src2, b_sgn) : src2;
        a_neg  = a_sgn && a_ext[XLEN-1];
        b_neg  = b_sgn && b_ext[XLEN-1];
        a_mag  = a_neg ? -a_ext : a_ext;
        b_mag  = b_neg ? -b_ext : b_ext;
        // most-negative W-bit value, already extended to XLEN
        min_w  = {XLEN{1'b1}} << (word ? 31 : XLEN - 1);
        div0   = (b_ext == '0);
        ovf    = a_sgn && (a_ext == min_w) && (b_ext == {XLEN{1'b1}});
        if (div0)
            corner_raw = op[1] ? a_ext : {XLEN{1'b1}};
        else
            corner_raw = op[1] ? '0 : a_ext;
        corner_res = word ? ext32(corner_raw, 1'b1) : corner_raw;
    end

    // One iteration step plus final sign fix-up and result selection
    logic [2*XLEN-1:0] p_next;
    logic [2*XLEN-1:0] p_s;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     r_next;
    logic              ge;
    logic [XLEN-1:0]   x_next;
    logic [XLEN-1:0]   q_s;
    logic [XLEN-1:0]   r_s;
    logic [XLEN-1:0]   res;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        p_next = {p_q[2*XLEN-2:0], 1'b0} + (x_q[XLEN-1] ? {{XLEN{1'b0}}, y_q} : '0);
        r_sh   = {r_q[XLEN-1:0], x_q[XLEN-1]};
        ge     = (r_sh >= {1'b0, y_q});
        r_next = ge ? (r_sh - {1'b0, y_q}) : r_sh;
        x_next = {x_q[XLEN-2:0], (state == S_DIV) && ge};
        p_s    = (a_neg_q ^ b_neg_q) ? -p_next : p_next;
        q_s    = (a_neg_q ^ b_neg_q) ? -x_next : x_next;
        r_s    = a_neg_q ? -r_next[XLEN-1:0] : r_next[XLEN-1:0];
        if (state == S_DIV)
            res = f3_q[1] ? r_s : q_s;
        else if (f3_q == 3'd0)
            res = p_s[XLEN-1:0];
        else
            res = XLEN'(p_s >> (word_q ? 32 : XLEN));
        final_res = word_q ? ext32(res, 1'b1) : res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            f3_q      <= '0;
            word_q    <= 1'b0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            p_q       <= '0;
            r_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rd_o      <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        f3_q    <= op[2:0];
                        word_q  <= word;
                        rd_o    <= rd_i;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        // left-align the scanned operand so bit XLEN-1 is always examined
                        x_q     <= (is_div ? a_mag : b_mag) << (word ? XLEN - 32 : 0);
                        y_q     <= is_div ? b_mag : a_mag;
                        p_q     <= '0;
                        r_q     <= '0;
                        cnt     <= word ? CW'(32) : CW'(XLEN);
                        if (!is_div) begin
                            state <= S_MUL;
                        end else if (div0 || ovf) begin
                            out_data  <= corner_res;
                            out_valid <= 1'b1;
                            cnt       <= '0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    p_q <= p_next;
                    r_q <= r_next;
                    x_q <= x_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        out_data  <= final_res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
